// File: rtl/coord_src_arbiter.sv
// coord_src_arbiter
// Round-robin arbiter sharing one coordinate-cleaning stage between N_SRC
// sources. The granted source's X/Y/Z sample is captured into a single output
// register and presented, tagged with its source index, on a valid/ready
// handshake. A pop and a new capture can happen on the same edge, so the
// stage sustains one sample per cycle.
//
// Optional feature: define COORD_ARB_STATS_EN to build one saturating 16-bit
// grant counter per source, readable through stat_sel/stat_cnt. Without it,
// stat_cnt is tied to zero and stat_sel/stat_clr are ignored.
module coord_src_arbiter #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [16*N_SRC-1:0] src_x,
    input  logic [16*N_SRC-1:0] src_y,
    input  logic [16*N_SRC-1:0] src_z,
    input  logic [N_SRC-1:0]    src_valid,
    output logic [N_SRC-1:0]    src_ready,
    input  logic [N_SRC-1:0]    src_en,
    output logic [15:0]         out_x,
    output logic [15:0]         out_y,
    output logic [15:0]         out_z,
    output logic [ID_W-1:0]     out_id,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [ID_W-1:0]     stat_sel,
    input  logic                stat_clr,
    output logic [15:0]         stat_cnt
);

    // Buffer occupancy is the whole state machine: EMPTY or FULL.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [ID_W-1:0] r_ptr;
    logic [15:0]     r_x;
    logic [15:0]     r_y;
    logic [15:0]     r_z;
    logic [ID_W-1:0] r_id;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] w_req;
    logic             w_any_req;
    logic [ID_W-1:0]  w_grant;
    logic [ID_W:0]    w_idx;
    logic             w_can_load;
    logic             w_xfer;
    logic             w_pop;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [0:0]       w_state_nxt;
    logic [15:0]      w_sel_x;
    logic [15:0]      w_sel_y;
    logic [15:0]      w_sel_z;

    // A disabled source is invisible to arbitration even if it is valid.
    assign w_req = src_valid & src_en;

    // The buffer may take a new sample when it is empty or being drained now.
    assign w_can_load = (r_state == ST_EMPTY) || out_ready;

    // Rotating-priority search: first requester at or after r_ptr (mod N_SRC).
    always_comb begin
        // NOTE: every net driven here gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        w_any_req = 1'b0;
        w_grant   = '0;
        w_idx     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_SRC)) begin
                w_idx = w_idx - (ID_W+1)'(N_SRC);
            end
            if (!w_any_req && w_req[w_idx[ID_W-1:0]]) begin
                w_any_req = 1'b1;
                w_grant   = w_idx[ID_W-1:0];
            end
        end
    end

    // Accept strobe goes only to the granted source; nothing is accepted in reset.
    always_comb begin
        src_ready = '0;
        if (reset_n && w_any_req && w_can_load) begin
            src_ready[w_grant] = 1'b1;
        end
    end

    // Transfer is the handshake of the granted source; pop is the downstream one.
    assign w_xfer = |(src_ready & src_valid);
    assign w_pop  = (r_state == ST_FULL) && out_ready;

    // Pointer moves just past the winner so it yields on the next decision.
    assign w_ptr_nxt = (w_grant == ID_W'(N_SRC-1)) ? '0 : (w_grant + 1'b1);

    // Sample mux for the granted source (each source owns a 16-bit slice).
    assign w_sel_x = src_x[{w_grant, 4'b0000} +: 16];
    assign w_sel_y = src_y[{w_grant, 4'b0000} +: 16];
    assign w_sel_z = src_z[{w_grant, 4'b0000} +: 16];

    // Next-state: fill on transfer, drain on a pop that is not refilled.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_pop && !w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Occupancy state and round-robin pointer; reset discards any held sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Output register: loads only on transfer, otherwise holds (stall-stable).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_z  <= '0;
            r_id <= '0;
        end else if (w_xfer) begin
            r_x  <= w_sel_x;
            r_y  <= w_sel_y;
            r_z  <= w_sel_z;
            r_id <= w_grant;
        end
    end

    assign out_x     = r_x;
    assign out_y     = r_y;
    assign out_z     = r_z;
    assign out_id    = r_id;
    assign out_valid = (r_state == ST_FULL);

`ifdef COORD_ARB_STATS_EN
    logic [15:0] r_cnt [N_SRC];

    // Per-source saturating grant counters; a clear beats a coincident grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this small counter array is reset explicitly because its
            // contents are architecturally visible; large data RAMs normally
            // are not reset.
            for (int i = 0; i < N_SRC; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_xfer && (r_cnt[w_grant] != 16'hFFFF)) begin
            r_cnt[w_grant] <= r_cnt[w_grant] + 16'd1;
        end
    end

    // Combinational read port; out-of-range selects read as zero.
    assign stat_cnt = (int'(stat_sel) < N_SRC) ? r_cnt[stat_sel] : 16'h0000;
`else
    // Statistics not built: inputs are deliberately ignored.
    logic w_unused_stats;
    assign w_unused_stats = ^{stat_sel, stat_clr};
    assign stat_cnt       = 16'h0000;
`endif

endmodule
